memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of ACCESS cycles without dmem_ack before the access is aborted.
REQ-002 SHALL have port clock, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port valid, input, 1, execute-stage result valid.
REQ-005 SHALL have port instruction, input, 32, instruction in the execute stage.
REQ-006 SHALL have port alu_res, input, 32, effective byte address from execute.
REQ-007 SHALL have port reg_2, input, 32, store source data.
REQ-008 SHALL have port dmem_req, output, 1, memory request, held until ack.
REQ-009 SHALL have port dmem_we, output, 1, 1 = write, 0 = read.
REQ-010 SHALL have port dmem_addr, output, 32, word-aligned address {addr[31:2],2'b00}.
REQ-011 SHALL have port dmem_wdata, output, 32, lane-replicated store data.
REQ-012 SHALL have port dmem_be, output, 4, byte enables.
REQ-013 SHALL have port dmem_ack, input, 1, memory completion.
REQ-014 SHALL have port dmem_rdata, input, 32, read word, valid when dmem_ack=1.
REQ-015 SHALL have port stall, output, 1, upstream must hold its inputs.
REQ-016 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port load_data, output, 32, extended load result, valid while done=1.
REQ-018 SHALL have port load_wen, output, 1, done & load & fault_code==00.
REQ-019 SHALL have port rd_out, output, 5, captured instruction[11:7].
REQ-020 SHALL have port fault_code, output, 2, 00 none, 01 misaligned, 10 timeout, 11 illegal funct3; valid while done=1.

Function
REQ-021 SHALL decode loads as opcode 0000011 (funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU) and stores as opcode 0100011 (funct3 000 SB, 001 SH, 010 SW); any other funct3 on these opcodes is illegal.
REQ-022 SHALL implement the FSM states IDLE, ACCESS and DONE; all outputs except stall SHALL be registered.
REQ-023 SHALL accept in IDLE when valid=1 and the opcode is a load or store, capturing alu_res, reg_2, funct3, load/store type and rd.
REQ-024 SHALL take no action and stay in IDLE for non-memory opcodes or valid=0.
REQ-025 Legal aligned accept: SHALL go to ACCESS with dmem_req=1, dmem_addr, dmem_we, dmem_be and dmem_wdata driven from the next cycle.
REQ-026 Misaligned accept (H with addr[0]=1; W with addr[1:0]!=0) or illegal funct3: SHALL issue no request, go directly to DONE, and set fault_code to 01 or 11.
REQ-027 SHALL drive stores as follows:
- SB: wdata={4{reg_2[7:0]}}, be=0001<<addr[1:0].
- SH: wdata={2{reg_2[15:0]}}, be=0011 if addr[1]=0, otherwise 1100.
- SW: wdata=reg_2, be=1111.
REQ-028 SHALL drive loads with dmem_we=0 and be=1111.
REQ-029 In ACCESS, SHALL hold all dmem_* outputs stable until a cycle with dmem_ack=1, then go to DONE with dmem_req=0 in the next cycle.
REQ-030 On ack, SHALL form load_data as follows:
- byte: rdata[8*addr[1:0]+:8].
- half: rdata[16*addr[1]+:16].
- LB/LH sign-extended; LBU/LHU zero-extended; LW the full word; stores 0.
REQ-031 SHALL count ACCESS cycles; if TIMEOUT cycles elapse without ack, SHALL deassert dmem_req, go to DONE with fault_code=10 and load_data=0.
REQ-032 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-033 Minimum latency: accept at edge N, ack in the first ACCESS cycle, done=1 in cycle N+2.
REQ-034 SHALL compute stall = (state!=IDLE) | (valid & memory opcode & state==IDLE).
REQ-035 SHALL ignore dmem_ack outside ACCESS.
REQ-036 SHALL ignore new valid inputs while in ACCESS or DONE.
REQ-037 SHALL hold load_data, rd_out and fault_code at their last values outside DONE.

Reset
REQ-038 reset=1 SHALL force IDLE at the next edge from any state, including mid-ACCESS, with no done pulse.
REQ-039 Reset values SHALL be 0 for dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, done, load_data, load_wen, rd_out and fault_code, and the timeout counter SHALL be 0.

Verification
REQ-040 LB at alu_res=0x1003, rdata=0x80FF_FF7F, ack in the first cycle -> dmem_addr=0x1000, be=1111, done at N+2, load_data=0xFFFF_FF80, load_wen=1.
REQ-041 SH at alu_res=0x2002, reg_2=0x1234_ABCD -> dmem_we=1, be=1100, wdata=0xABCD_ABCD; ack after 3 cycles -> dmem_req held 3 cycles, done=1, load_wen=0.
REQ-042 LW at alu_res=0x0000_0006 -> no dmem_req, done at N+1, fault_code=01, load_wen=0.
REQ-043 LHU at 0x10, no ack with TIMEOUT=16 -> dmem_req high exactly 16 cycles, then done with fault_code=10.
REQ-044 reset asserted in the second ACCESS cycle of a load -> dmem_req=0 and state IDLE after the edge, no done; a later ack is ignored.
REQ-045 Load opcode with funct3=011 -> no request, done with fault_code=11; ADD opcode with valid=1 -> stall=0 and no request.

Source files
------------

// File: rtl/memory_access.sv
// Memory-stage load/store unit: decodes execute-stage memory ops, issues one
// data-memory request with an ack timeout, and returns the extended load result.
module memory_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] instruction,
    input  logic [31:0] alu_res,
    input  logic [31:0] reg_2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        load_wen,
    output logic [4:0]  rd_out,
    output logic [1:0]  fault_code
);

    localparam int unsigned CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         f3_q;
    logic               is_load_q;
    logic [1:0]         addr_lo_q;
    logic [4:0]         rd_q;

    logic               req_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               done_q;
    logic [31:0]        load_data_q;
    logic               load_wen_q;
    logic [4:0]         rd_out_q;
    logic [1:0]         fault_q;

    logic               is_load_c;
    logic               is_store_c;
    logic               mem_op_c;
    logic [2:0]         f3_c;
    logic               illegal_c;
    logic               misalign_c;
    logic [3:0]         st_be_c;
    logic [31:0]        st_wdata_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        load_ext_c;
    logic               unused_ok;

    assign unused_ok = ^instruction[31:15];

    // Decode of the execute-stage instruction and store lane formatting
    always_comb begin
        is_load_c  = (instruction[6:0] == OPC_LOAD);
        is_store_c = (instruction[6:0] == OPC_STORE);
        mem_op_c   = is_load_c || is_store_c;
        f3_c       = instruction[14:12];
        illegal_c  = 1'b0;
        if (is_load_c) begin
            illegal_c = (f3_c == 3'b011) || (f3_c[2:1] == 2'b11);
        end
        if (is_store_c) begin
            illegal_c = f3_c[2] || (f3_c[1:0] == 2'b11);
        end
        misalign_c = ((f3_c[1:0] == 2'b01) && alu_res[0]) ||
                     ((f3_c[1:0] == 2'b10) && (alu_res[1:0] != 2'b00));
        case (f3_c[1:0])
            2'b00: begin
                st_be_c    = 4'b0001 << alu_res[1:0];
                st_wdata_c = {4{reg_2[7:0]}};
            end
            2'b01: begin
                st_be_c    = alu_res[1] ? 4'b1100 : 4'b0011;
                st_wdata_c = {2{reg_2[15:0]}};
            end
            default: begin
                st_be_c    = 4'b1111;
                st_wdata_c = reg_2;
            end
        endcase
        if (is_load_c) begin
            st_be_c    = 4'b1111;
            st_wdata_c = '0;
        end
    end

    // Lane select and sign/zero extension of the returned read word
    always_comb begin
        byte_c = 8'(dmem_rdata >> {addr_lo_q, 3'b000});
        half_c = 16'(dmem_rdata >> {addr_lo_q[1], 4'b0000});
        case (f3_q)
            3'b000:  load_ext_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_ext_c = {{16{half_c[15]}}, half_c};
            3'b100:  load_ext_c = {24'h000000, byte_c};
            3'b101:  load_ext_c = {16'h0000, half_c};
            default: load_ext_c = dmem_rdata;
        endcase
        if (!is_load_q) begin
            load_ext_c = '0;
        end
    end

    assign stall = (state_q != S_IDLE) || (valid && mem_op_c);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            is_load_q   <= 1'b0;
            addr_lo_q   <= '0;
            rd_q        <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            done_q      <= 1'b0;
            load_data_q <= '0;
            load_wen_q  <= 1'b0;
            rd_out_q    <= '0;
            fault_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid && mem_op_c) begin
                        f3_q      <= f3_c;
                        is_load_q <= is_load_c;
                        addr_lo_q <= alu_res[1:0];
                        rd_q      <= instruction[11:7];
                        cnt_q     <= '0;
                        if (illegal_c || misalign_c) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            fault_q     <= illegal_c ? 2'b11 : 2'b01;
                            load_data_q <= '0;
                            load_wen_q  <= 1'b0;
                            rd_out_q    <= instruction[11:7];
                        end else begin
                            state_q <= S_ACCESS;
                            req_q   <= 1'b1;
                            we_q    <= is_store_c;
                            addr_q  <= {alu_res[31:2], 2'b00};
                            wdata_q <= st_wdata_c;
                            be_q    <= st_be_c;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack arriving in the last allowed cycle still completes normally
                    if (dmem_ack) begin
                        state_q     <= S_DONE;
                        req_q       <= 1'b0;
                        done_q      <= 1'b1;
                        fault_q     <= 2'b00;
                        load_data_q <= load_ext_c;
                        load_wen_q  <= is_load_q;
                        rd_out_q    <= rd_q;
                        cnt_q       <= '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q     <= S_DONE;
                        req_q       <= 1'b0;
                        done_q      <= 1'b1;
                        fault_q     <= 2'b10;
                        load_data_q <= '0;
                        load_wen_q  <= 1'b0;
                        rd_out_q    <= rd_q;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    done_q     <= 1'b0;
                    load_wen_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign done       = done_q;
    assign load_data  = load_data_q;
    assign load_wen   = load_wen_q;
    assign rd_out     = rd_out_q;
    assign fault_code = fault_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed corner cases followed by
// randomized loads/stores compared against a byte-lane arithmetic model.
module tb_memory_access;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;
    localparam logic [6:0]  OPC_ADD   = 7'b0110011;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] alu_res = '0;
    logic [31:0] reg_2 = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        load_wen;
    logic [4:0]  rd_out;
    logic [1:0]  fault_code;

    int checks = 0;
    int failures = 0;

    memory_access #(.TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .instruction (instruction),
        .alu_res     (alu_res),
        .reg_2       (reg_2),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .stall       (stall),
        .done        (done),
        .load_data   (load_data),
        .load_wen    (load_wen),
        .rd_out      (rd_out),
        .fault_code  (fault_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        return {17'($urandom), f3, rd, opc};
    endfunction

    // Reference: access size is 1<<f3[1:0] bytes, address must be a multiple of it
    function automatic logic [1:0] m_fault(input logic ld, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        bit legal;
        if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        if (!legal) return 2'b11;
        sz = 1 << int'(f3[1:0]);
        if ((int'(a[1:0]) % sz) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int unsigned k;
        logic [31:0] v;
        k = int'(a[1:0]);
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * k)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rd >> (16 * (k / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] r2);
        case (f3)
            3'd0:    return (r2 & 32'hFF) * 32'h0101_0101;
            3'd1:    return (r2 & 32'hFFFF) * 32'h0001_0001;
            default: return r2;
        endcase
    endfunction

    function automatic logic [31:0] m_be(input logic ld, input logic [2:0] f3, input logic [31:0] a);
        int unsigned k;
        k = int'(a[1:0]);
        if (ld) return 32'd15;
        case (f3)
            3'd0:    return 32'd1 << k;
            3'd1:    return (k >= 2) ? 32'd12 : 32'd3;
            default: return 32'd15;
        endcase
    endfunction

    // One memory op: ack arrives in ACCESS cycle ack_at (0-based); ack_at >= TIMEOUT means never
    task automatic run_txn(input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] r2,
                           input int ack_at, input logic [31:0] rdat);
        logic        ld;
        logic [2:0]  f3;
        logic [1:0]  flt;
        logic [1:0]  efault;
        logic [31:0] eld;
        int          ncyc;
        ld  = (ins[6:0] == OPC_LOAD);
        f3  = ins[14:12];
        flt = m_fault(ld, f3, addr);
        @(negedge clock);
        valid = 1'b1; instruction = ins; alu_res = addr; reg_2 = r2; dmem_ack = 1'b0;
        #1 chk("stall_on_accept", stall, 1);
        @(posedge clock); #1 valid = 1'b0;
        @(negedge clock);
        if (flt != 2'b00) begin
            efault = flt;
            eld    = '0;
            chk("fault_done", done, 1);
            chk("fault_code", fault_code, efault);
            chk("fault_wen", load_wen, 0);
            chk("fault_noreq", dmem_req, 0);
            chk("fault_ldata", load_data, eld);
            chk("fault_rd", rd_out, ins[11:7]);
        end else begin
            ncyc = (ack_at < TIMEOUT) ? ack_at + 1 : TIMEOUT;
            for (int i = 0; i < ncyc; i++) begin
                chk("acc_req", dmem_req, 1);
                chk("acc_we", dmem_we, !ld);
                chk("acc_addr", dmem_addr, {addr[31:2], 2'b00});
                chk("acc_be", dmem_be, m_be(ld, f3, addr));
                if (!ld) chk("acc_wdata", dmem_wdata, m_wdata(f3, r2));
                chk("acc_stall", stall, 1);
                chk("acc_nodone", done, 0);
                valid       = 1'($urandom);
                instruction = mk(OPC_STORE, 3'b010, 5'd9);
                dmem_ack    = (i == ack_at);
                dmem_rdata  = (i == ack_at) ? rdat : $urandom;
                @(posedge clock); #1 dmem_ack = 1'b0;
                @(negedge clock);
            end
            valid  = 1'b0;
            efault = (ack_at < TIMEOUT) ? 2'b00 : 2'b10;
            eld    = (ack_at < TIMEOUT && ld) ? m_load(f3, addr, rdat) : 32'h0;
            chk("cmp_done", done, 1);
            chk("cmp_req", dmem_req, 0);
            chk("cmp_fault", fault_code, efault);
            chk("cmp_ldata", load_data, eld);
            chk("cmp_wen", load_wen, (ack_at < TIMEOUT) && ld);
            chk("cmp_rd", rd_out, ins[11:7]);
        end
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
        @(posedge clock); #1 dmem_ack = 1'b0;
        @(negedge clock);
        chk("post_done", done, 0);
        chk("post_wen", load_wen, 0);
        chk("post_req", dmem_req, 0);
        chk("post_stall", stall, 0);
        chk("hold_ldata", load_data, eld);
        chk("hold_fault", fault_code, efault);
        chk("hold_rd", rd_out, ins[11:7]);
    endtask

    initial begin
        logic [6:0]  opc;
        logic [2:0]  f3;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_done", done, 0);
        chk("rst_ldata", load_data, 0);
        chk("rst_wen", load_wen, 0);
        chk("rst_rd", rd_out, 0);
        chk("rst_fault", fault_code, 0);
        chk("rst_stall", stall, 0);
        reset = 1'b0;

        // LB sign-extended byte 3, ack in first cycle
        run_txn(mk(OPC_LOAD, 3'b000, 5'd5), 32'h0000_1003, 32'h0, 0, 32'h80FF_FF7F);
        // SH upper half, ack on third cycle
        run_txn(mk(OPC_STORE, 3'b001, 5'd0), 32'h0000_2002, 32'h1234_ABCD, 2, 32'h0);
        // Misaligned LW
        run_txn(mk(OPC_LOAD, 3'b010, 5'd7), 32'h0000_0006, 32'h0, 0, 32'h0);
        // LHU timeout
        run_txn(mk(OPC_LOAD, 3'b101, 5'd12), 32'h0000_0010, 32'h0, 100, 32'h0);
        // Ack in the very last allowed cycle
        run_txn(mk(OPC_LOAD, 3'b100, 5'd13), 32'h0000_0021, 32'h0, TIMEOUT - 1, 32'h1122_3344);
        // Illegal load funct3
        run_txn(mk(OPC_LOAD, 3'b011, 5'd2), 32'h0000_0000, 32'h0, 0, 32'h0);

        // Reset in the second ACCESS cycle of a load
        @(negedge clock);
        valid = 1'b1; instruction = mk(OPC_LOAD, 3'b010, 5'd3); alu_res = 32'h40;
        @(posedge clock); #1 valid = 1'b0;
        @(negedge clock);
        chk("r_mid_req1", dmem_req, 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("r_mid_req0", dmem_req, 0);
        chk("r_mid_nodone", done, 0);
        chk("r_mid_idle", stall, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clock); #1 dmem_ack = 1'b0;
        @(negedge clock);
        chk("r_late_ack_done", done, 0);
        chk("r_late_ack_req", dmem_req, 0);
        chk("r_late_ack_wen", load_wen, 0);

        // Non-memory opcode is ignored
        @(negedge clock);
        valid = 1'b1; instruction = mk(OPC_ADD, 3'b000, 5'd4);
        #1 chk("add_stall", stall, 0);
        @(posedge clock); #1 valid = 1'b0;
        @(negedge clock);
        chk("add_req", dmem_req, 0);
        chk("add_done", done, 0);

        // Randomized loads and stores
        for (int t = 0; t < 150; t++) begin
            opc = (($urandom % 2) != 0) ? OPC_LOAD : OPC_STORE;
            f3  = 3'($urandom);
            run_txn(mk(opc, f3, 5'($urandom)), $urandom, $urandom,
                    int'($urandom_range(0, 19)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
